// File: rtl/decode_queue.sv
// RV32I/RV64I (+optional M) instruction decoder feeding a DEPTH-entry FIFO.
// Fetch pushes raw words; issue pops fully decoded entries in order.
module decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int EN_M  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [1:0]       out_unit,
  output logic [2:0]       out_sub_unit,
  output logic [3:0]       out_sel,
  output logic [2:0]       out_imm_type,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic             out_word,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  // Handshake: a transfer happens on a side in any cycle where its valid and
  // ready are both high; in_ready comes from registered occupancy only.

  localparam bit RV64  = (XLEN == 64);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_B = $clog2(DEPTH + 1);

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [1:0]      unit;
    logic [2:0]      sub_unit;
    logic [3:0]      sel;
    logic [2:0]      imm_type;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            word;
    logic            illegal;
  } entry_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------- decode ----------------
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       op32;
  logic       is_srl;
  logic       sh_ok;
  logic       ill;
  logic [1:0] unit;
  logic [2:0] sub;
  logic [3:0] sel;
  logic [2:0] immt;
  logic       use_rd, use_rs1, use_rs2, word;
  entry_t     dec;

  assign opc    = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign op32   = opc[3];
  assign is_srl = (f3 == 3'd5);

  // RV64 immediate shifts have a 6-bit shamt, so only funct6 is fixed.
  always_comb begin
    sh_ok = 1'b0;
    if (op32 || !RV64)
      sh_ok = (f7 == 7'b0000000) || (is_srl && f7 == 7'b0100000);
    else
      sh_ok = (in_instr[31:26] == 6'b000000) || (is_srl && in_instr[31:26] == 6'b010000);
  end

  always_comb begin
    ill = 1'b0; unit = 2'd0; sub = 3'd0; sel = 4'd0; immt = IMM_NONE;
    use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; word = 1'b0;
    case (opc)
      7'b0110111: begin immt = IMM_U; use_rd = 1'b1; end
      7'b0010111: begin sel = 4'd1; immt = IMM_U; use_rd = 1'b1; end
      7'b1101111: begin sel = 4'd2; immt = IMM_J; use_rd = 1'b1; end
      7'b1100111: begin
        sel = 4'd3; immt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
        ill = (f3 != 3'd0);
      end
      7'b1100011: begin
        sub = 3'd1; immt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3)
          3'd0: sel = 4'd0;
          3'd1: sel = 4'd1;
          3'd4: sel = 4'd2;
          3'd5: sel = 4'd3;
          3'd6: sel = 4'd4;
          3'd7: sel = 4'd5;
          default: ill = 1'b1;
        endcase
      end
      7'b0000011: begin
        unit = 2'd1; immt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
        case (f3)
          3'd0: sel = 4'd0;
          3'd1: sel = 4'd1;
          3'd2: sel = 4'd2;
          3'd4: sel = 4'd3;
          3'd5: sel = 4'd4;
          3'd6: begin sel = 4'd5; ill = !RV64; end
          3'd3: begin sel = 4'd6; ill = !RV64; end
          default: ill = 1'b1;
        endcase
      end
      7'b0100011: begin
        unit = 2'd1; sub = 3'd1; immt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3)
          3'd0, 3'd1, 3'd2: sel = {1'b0, f3};
          3'd3: begin sel = 4'd3; ill = !RV64; end
          default: ill = 1'b1;
        endcase
      end
      7'b0010011, 7'b0011011: begin
        immt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1; word = op32;
        ill = op32 && !RV64;
        case (f3)
          3'd0: sub = 3'd2;
          3'd1: begin sub = 3'd4; ill = ill || !sh_ok; end
          3'd5: begin sub = 3'd4; sel = in_instr[30] ? 4'd2 : 4'd1; ill = ill || !sh_ok; end
          3'd2: begin sub = 3'd3; sel = 4'd0; ill = ill || op32; end
          3'd3: begin sub = 3'd3; sel = 4'd1; ill = ill || op32; end
          3'd4: begin sub = 3'd3; sel = 4'd2; ill = ill || op32; end
          3'd6: begin sub = 3'd3; sel = 4'd3; ill = ill || op32; end
          default: begin sub = 3'd3; sel = 4'd4; ill = ill || op32; end
        endcase
      end
      7'b0110011, 7'b0111011: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; word = op32;
        ill = op32 && !RV64;
        if (f7 == 7'b0000001) begin
          sub = 3'd5; sel = {1'b0, f3};
          if (EN_M == 0) ill = 1'b1;
          if (op32 && (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3)) ill = 1'b1;
        end else if (f7 == 7'b0000000) begin
          case (f3)
            3'd0: sub = 3'd2;
            3'd1: sub = 3'd4;
            3'd5: begin sub = 3'd4; sel = 4'd1; end
            3'd2: begin sub = 3'd3; sel = 4'd0; ill = ill || op32; end
            3'd3: begin sub = 3'd3; sel = 4'd1; ill = ill || op32; end
            3'd4: begin sub = 3'd3; sel = 4'd2; ill = ill || op32; end
            3'd6: begin sub = 3'd3; sel = 4'd3; ill = ill || op32; end
            default: begin sub = 3'd3; sel = 4'd4; ill = ill || op32; end
          endcase
        end else if (f7 == 7'b0100000) begin
          case (f3)
            3'd0: begin sub = 3'd2; sel = 4'd1; end
            3'd5: begin sub = 3'd4; sel = 4'd2; end
            default: ill = 1'b1;
          endcase
        end else begin
          ill = 1'b1;
        end
      end
      7'b0001111: begin
        unit = 2'd3;
        case (f3)
          3'd0: sub = 3'd0;
          3'd1: sub = 3'd1;
          default: ill = 1'b1;
        endcase
      end
      7'b1110011: begin
        if (f3 == 3'd0) begin
          unit = 2'd3;
          if (in_instr[11:7] != 5'd0 || in_instr[19:15] != 5'd0) ill = 1'b1;
          if (in_instr[31:20] == 12'd0)      sub = 3'd2;
          else if (in_instr[31:20] == 12'd1) sub = 3'd3;
          else                               ill = 1'b1;
        end else if (f3 == 3'd4) begin
          ill = 1'b1;
        end else begin
          unit = 2'd2; sub = {2'b00, f3[2]}; sel = {2'b00, f3[1:0] - 2'd1};
          immt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    dec          = '0;
    dec.pc       = in_pc;
    dec.illegal  = ill;
    if (!ill) begin
      dec.unit     = unit;
      dec.sub_unit = sub;
      dec.sel      = sel;
      dec.imm_type = immt;
      dec.word     = word;
      dec.rd       = use_rd  ? in_instr[11:7]  : 5'd0;
      dec.rs1      = use_rs1 ? in_instr[19:15] : 5'd0;
      dec.rs2      = use_rs2 ? in_instr[24:20] : 5'd0;
      case (immt)
        IMM_I:   dec.imm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
        IMM_S:   dec.imm = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
        IMM_B:   dec.imm = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                   in_instr[30:25], in_instr[11:8], 1'b0});
        IMM_U:   dec.imm = sext32({in_instr[31:12], 12'b0});
        IMM_J:   dec.imm = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                   in_instr[20], in_instr[30:21], 1'b0});
        default: dec.imm = '0;
      endcase
    end
  end

  // ---------------- FIFO ----------------
  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_B-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   illegal_cnt_q, illegal_cnt_d;
  logic               push, pop;
  entry_t             head;

  assign in_ready  = !rst && (count_q < CNT_B'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    illegal_cnt_d = illegal_cnt_q;
    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push && dec.illegal && illegal_cnt_q != '1) illegal_cnt_d = illegal_cnt_q + 1'b1;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      illegal_cnt_q <= '0;
    end else begin
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // Payload storage needs no reset: the head is masked whenever count is 0.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec;
  end

  assign head         = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_pc       = head.pc;
  assign out_unit     = head.unit;
  assign out_sub_unit = head.sub_unit;
  assign out_sel      = head.sel;
  assign out_imm_type = head.imm_type;
  assign out_imm      = head.imm;
  assign out_rd       = head.rd;
  assign out_rs1      = head.rs1;
  assign out_rs2      = head.rs2;
  assign out_word     = head.word;
  assign out_illegal  = head.illegal;
  assign illegal_cnt  = illegal_cnt_q;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: an RV32 (no M) and an RV64 (+M, 2-bit counter)
// instance share one stimulus stream; vectors carry hand-computed decodes.
module tb_decode_queue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        a_in_ready, a_out_valid, a_word, a_illegal;
  logic [31:0] a_pc, a_imm;
  logic [1:0]  a_unit;
  logic [2:0]  a_sub, a_immt;
  logic [3:0]  a_sel;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [15:0] a_cnt;

  logic        b_in_ready, b_out_valid, b_word, b_illegal;
  logic [63:0] b_pc, b_imm;
  logic [1:0]  b_unit;
  logic [2:0]  b_sub, b_immt;
  logic [3:0]  b_sel;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [1:0]  b_cnt;

  decode_queue #(.XLEN(32), .DEPTH(2), .EN_M(0), .CNT_W(16)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_unit(a_unit), .out_sub_unit(a_sub), .out_sel(a_sel),
    .out_imm_type(a_immt), .out_imm(a_imm), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_word(a_word), .out_illegal(a_illegal), .illegal_cnt(a_cnt));

  decode_queue #(.XLEN(64), .DEPTH(2), .EN_M(1), .CNT_W(2)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_unit(b_unit), .out_sub_unit(b_sub), .out_sel(b_sel),
    .out_imm_type(b_immt), .out_imm(b_imm), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_word(b_word), .out_illegal(b_illegal), .illegal_cnt(b_cnt));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    bit          ill, only64, needm;
    logic [1:0]  unit;
    logic [2:0]  sub;
    logic [3:0]  sel;
    logic [2:0]  immt;
    logic [63:0] imm;
    logic [4:0]  rd, rs1, rs2;
    bit          word;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [31:0] instr, input bit ill, only64, needm,
                              input int unit, sub, sel, immt, input logic [63:0] imm,
                              input int rd, rs1, rs2, input bit word);
    vec_t v;
    v.instr = instr; v.ill = ill; v.only64 = only64; v.needm = needm;
    v.unit = 2'(unit); v.sub = 3'(sub); v.sel = 4'(sel); v.immt = 3'(immt); v.imm = imm;
    v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.word = word;
    return v;
  endfunction

  // Expected head for the RV32/no-M instance (is64 = 0) or the RV64/M instance.
  function automatic logic [159:0] exp_pack(input vec_t v, input bit is64, input logic [63:0] pc);
    logic [63:0] p, im;
    bit il;
    p  = is64 ? pc : {32'b0, pc[31:0]};
    im = is64 ? v.imm : {32'b0, v.imm[31:0]};
    il = v.ill || (!is64 && (v.only64 || v.needm));
    if (il) return {3'b0, 1'b1, 92'b0, p};
    return {3'b0, 1'b0, v.unit, v.sub, v.sel, v.immt, im, v.rd, v.rs1, v.rs2, v.word, p};
  endfunction

  function automatic logic [159:0] act_a();
    return {3'b0, a_illegal, a_unit, a_sub, a_sel, a_immt, 32'b0, a_imm,
            a_rd, a_rs1, a_rs2, a_word, 32'b0, a_pc};
  endfunction

  function automatic logic [159:0] act_b();
    return {3'b0, b_illegal, b_unit, b_sub, b_sel, b_immt, b_imm,
            b_rd, b_rs1, b_rs2, b_word, b_pc};
  endfunction

  // ---------------- driver ----------------
  task automatic push_one(input logic [31:0] ins, input logic [63:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag, input logic [1:0] exp_ready);
    chk({tag, "_in_ready"},  {a_in_ready, b_in_ready}, exp_ready);
    chk({tag, "_out_valid"}, {a_out_valid, b_out_valid}, 0);
    chk({tag, "_fields32"},  act_a(), 0);
    chk({tag, "_fields64"},  act_b(), 0);
  endtask

  int n_ill32, n_ill64, accept_cyc, cyc;
  logic [15:0] saved_a;
  logic [1:0]  saved_b;
  bit will_accept;

  initial begin
    vt.push_back(mk(32'hFFB10093, 0,0,0, 0,2,0,1, 64'hFFFFFFFFFFFFFFFB, 1,2,0, 0)); // addi
    vt.push_back(mk(32'hFE000EE3, 0,0,0, 0,1,0,3, 64'hFFFFFFFFFFFFFFFC, 0,0,0, 0)); // beq -4
    vt.push_back(mk(32'h022081B3, 0,0,1, 0,5,0,0, 64'h0, 3,1,2, 0));                 // mul
    vt.push_back(mk(32'h123452B7, 0,0,0, 0,0,0,4, 64'h12345000, 5,0,0, 0));         // lui
    vt.push_back(mk(32'h800000B7, 0,0,0, 0,0,0,4, 64'hFFFFFFFF80000000, 1,0,0, 0)); // lui neg
    vt.push_back(mk(32'h008000EF, 0,0,0, 0,0,2,5, 64'h8, 1,0,0, 0));                // jal
    vt.push_back(mk(32'h00008067, 0,0,0, 0,0,3,1, 64'h0, 0,1,0, 0));                // jalr
    vt.push_back(mk(32'h00209463, 0,0,0, 0,1,1,3, 64'h8, 0,1,2, 0));                // bne
    vt.push_back(mk(32'h402081B3, 0,0,0, 0,2,1,0, 64'h0, 3,1,2, 0));                // sub
    vt.push_back(mk(32'h4020D1B3, 0,0,0, 0,4,2,0, 64'h0, 3,1,2, 0));                // sra
    vt.push_back(mk(32'h7FF2F213, 0,0,0, 0,3,4,1, 64'h7FF, 4,5,0, 0));              // andi
    vt.push_back(mk(32'h40315093, 0,0,0, 0,4,2,1, 64'h403, 1,2,0, 0));              // srai 3
    vt.push_back(mk(32'h02011093, 0,1,0, 0,4,0,1, 64'h20, 1,2,0, 0));               // slli 32
    vt.push_back(mk(32'h42015093, 0,1,0, 0,4,2,1, 64'h420, 1,2,0, 0));              // srai 32
    vt.push_back(mk(32'hFF83A303, 0,0,0, 1,0,2,1, 64'hFFFFFFFFFFFFFFF8, 6,7,0, 0)); // lw
    vt.push_back(mk(32'h00014083, 0,0,0, 1,0,3,1, 64'h0, 1,2,0, 0));                // lbu
    vt.push_back(mk(32'h0003B303, 0,1,0, 1,0,6,1, 64'h0, 6,7,0, 0));                // ld
    vt.push_back(mk(32'h0020A623, 0,0,0, 1,1,2,2, 64'hC, 0,1,2, 0));                // sw
    vt.push_back(mk(32'h003100BB, 0,1,0, 0,2,0,0, 64'h0, 1,2,3, 1));                // addw
    vt.push_back(mk(32'h023100BB, 0,1,1, 0,5,0,0, 64'h0, 1,2,3, 1));                // mulw
    vt.push_back(mk(32'h3000A2F3, 0,0,0, 2,0,1,1, 64'h300, 5,1,0, 0));              // csrrs
    vt.push_back(mk(32'h3051D073, 0,0,0, 2,1,0,1, 64'h305, 0,3,0, 0));              // csrrwi
    vt.push_back(mk(32'h00000073, 0,0,0, 3,2,0,0, 64'h0, 0,0,0, 0));                // ecall
    vt.push_back(mk(32'h00100073, 0,0,0, 3,3,0,0, 64'h0, 0,0,0, 0));                // ebreak
    vt.push_back(mk(32'h000000F3, 1,0,0, 0,0,0,0, 64'h0, 0,0,0, 0));                // ecall rd!=0
    vt.push_back(mk(32'h0FF0000F, 0,0,0, 3,0,0,0, 64'h0, 0,0,0, 0));                // fence
    vt.push_back(mk(32'h0000100F, 0,0,0, 3,1,0,0, 64'h0, 0,0,0, 0));                // fence.i
    vt.push_back(mk(32'h00000000, 1,0,0, 0,0,0,0, 64'h0, 0,0,0, 0));                // [1:0]!=11
    vt.push_back(mk(32'h202081B3, 1,0,0, 0,0,0,0, 64'h0, 0,0,0, 0));                // bad funct7
    vt.push_back(mk(32'h00002063, 1,0,0, 0,0,0,0, 64'h0, 0,0,0, 0));                // bad branch f3

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk_idle("reset", 2'b00);
    chk("reset_cnt", {a_cnt, b_cnt}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset_ready", {a_in_ready, b_in_ready}, 2'b11);

    // decode table: one push, one cycle later inspect and pop
    n_ill32 = 0; n_ill64 = 0;
    out_ready = 1'b1;
    for (int i = 0; i < vt.size(); i++) begin
      logic [63:0] pc;
      pc = 64'hA000_0000_8000_0000 + 64'(i * 4);
      push_one(vt[i].instr, pc);
      chk($sformatf("vec%0d_valid", i), {a_out_valid, b_out_valid}, 2'b11);
      chk($sformatf("vec%0d_rv32", i), act_a(), exp_pack(vt[i], 1'b0, pc));
      chk($sformatf("vec%0d_rv64", i), act_b(), exp_pack(vt[i], 1'b1, pc));
      if (vt[i].ill || vt[i].only64 || vt[i].needm) n_ill32++;
      if (vt[i].ill) n_ill64++;
      @(negedge clk);
    end
    chk("table_drained", {a_out_valid, b_out_valid}, 0);
    chk("table_cnt32", a_cnt, 160'(n_ill32));
    chk("table_cnt64_sat", b_cnt, 160'((n_ill64 > 3) ? 3 : n_ill64));

    // backpressure: three back-to-back pushes into a 2-deep FIFO
    out_ready = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_instr = 32'hFFB10093; in_pc = 64'h100 + 64'(k * 4);
      exp_q.push_back(in_pc);
      @(negedge clk);
    end
    chk("bp_full_ready", {a_in_ready, b_in_ready}, 2'b00);
    in_pc = 64'h108; in_instr = 32'h402081B3;
    exp_q.push_back(in_pc);
    @(negedge clk);
    chk("bp_held_ready", {a_in_ready, b_in_ready}, 2'b00);
    chk("bp_head_pc", {a_pc, b_pc}, {32'h100, 64'h100});
    out_ready = 1'b1;
    accept_cyc = -1;
    cyc = 0;
    while (cyc < 20 && exp_q.size() > 0) begin
      logic [63:0] e;
      will_accept = in_valid && a_in_ready;
      if (will_accept) accept_cyc = cyc;
      if (a_out_valid) begin
        e = exp_q.pop_front();
        chk($sformatf("bp_order%0d", cyc), {a_pc, b_pc}, {e[31:0], e});
      end
      @(negedge clk);
      if (will_accept) in_valid = 1'b0;
      cyc++;
    end
    chk("bp_drain_budget", 160'(exp_q.size()), 0);
    chk("bp_accept_cycle", 160'(accept_cyc), 1);
    chk("bp_empty", {a_out_valid, b_out_valid}, 0);

    // flush with 1 and 2 buffered entries; the concurrent push must vanish
    for (int pre = 1; pre <= 2; pre++) begin
      out_ready = 1'b0;
      for (int k = 0; k < pre; k++) push_one(32'hFFB10093, 64'h200 + 64'(k * 4));
      saved_a = a_cnt; saved_b = b_cnt;
      flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 64'h2F0;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk($sformatf("flush%0d_valid", pre), {a_out_valid, b_out_valid}, 0);
      chk($sformatf("flush%0d_ready", pre), {a_in_ready, b_in_ready}, 2'b11);
      chk($sformatf("flush%0d_cnt", pre), {a_cnt, b_cnt}, {saved_a, saved_b});
      push_one(32'h123452B7, 64'h300);
      chk($sformatf("flush%0d_newhead", pre), {a_pc, b_pc, a_out_valid}, {32'h300, 64'h300, 1'b1});
      out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("flush%0d_drained", pre), {a_out_valid, b_out_valid}, 0);
    end

    // reset mid-stream
    out_ready = 1'b0;
    push_one(32'hFFB10093, 64'h400);
    push_one(32'h00000000, 64'h404);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("midrst", 2'b00);
    chk("midrst_cnt", {a_cnt, b_cnt}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_after_ready", {a_in_ready, b_in_ready}, 2'b11);
    chk("midrst_after_valid", {a_out_valid, b_out_valid}, 0);

    // illegal counter saturation on the 2-bit instance
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00000000;
    for (int k = 0; k < 5; k++) begin
      in_pc = 64'h500 + 64'(k * 4);
      @(negedge clk);
      if (k == 1) chk("sat_cnt64_mid", b_cnt, 2);
    end
    in_valid = 1'b0;
    chk("sat_cnt64", b_cnt, 3);
    chk("sat_cnt32", a_cnt, 5);
    chk("sat_last_head", {a_illegal, a_pc, b_illegal, b_pc}, {1'b1, 32'h510, 1'b1, 64'h510});
    @(negedge clk);
    chk("sat_drained", {a_out_valid, b_out_valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
